stream_demux2: RTL

STREAM_DEMUX2 -- requirements
Module: stream_demux2

---
 rtl/fifo2.sv | 79 +++++++
 rtl/stream_demux2.sv | 50 +++++
 2 files changed

// File: rtl/fifo2.sv
// Two-entry FIFO with registered occupancy, used once per demux output.
// Pops while empty and pushes while full are ignored internally.
module fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    localparam int DEPTH = 2;
    localparam int PTR_W = 1;
    localparam int ONE   = 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = ONE[PTR_W-1:0];
    localparam logic [PTR_W:0]   CNT_ONE  = ONE[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        do_pop  = pop && (count_q != '0);
        do_push = push && (count_q != CNT_FULL);

        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; valid masks whatever it holds.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign full  = (count_q == CNT_FULL);
    assign valid = (count_q != '0);
    assign dout  = mem_q[rd_ptr_q];

endmodule

// File: rtl/stream_demux2.sv
// Routes a valid/ready stream to one of two outputs, each buffered by its own
// two-entry FIFO so a stalled output never blocks traffic bound for the other.
module stream_demux2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
);

    logic full0, full1;
    logic push0, push1;

    // Ready looks only at the selected FIFO's fullness, never at downstream ready.
    assign in_ready = in_sel ? !full1 : !full0;
    assign push0    = in_valid && in_ready && !in_sel;
    assign push1    = in_valid && in_ready && in_sel;

    fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (push0),
        .din   (in_data),
        .full  (full0),
        .pop   (out0_ready),
        .valid (out0_valid),
        .dout  (out0_data)
    );

    fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (push1),
        .din   (in_data),
        .full  (full1),
        .pop   (out1_ready),
        .valid (out1_valid),
        .dout  (out1_data)
    );

endmodule
